// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the memory-side burst scheduler:
//   arb_state_t : scheduler FSM states
//   grant_t     : direction of the last granted burst (GRANT_WR / GRANT_RD)
//   clog2       : constant ceil(log2) helper used for counter sizing
package fifo_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    WR_CMD  = 3'd2,
    WR_DATA = 3'd3,
    RD_CMD  = 3'd4,
    RD_DATA = 3'd5
  } arb_state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// frame_addr_counter
// Burst start-address generator for one direction of frame-buffer traffic.
// Steps by BURST_LEN words on each advance and wraps to 0 after the last
// burst of a frame, flagging the wrap with a one-cycle pulse.
// Ports:
//   clk        : memory-domain clock
//   rst_n      : asynchronous active-low reset
//   advance    : one-cycle request to move to the next burst address
//   addr       : current burst start word address
//   wrap_pulse : high for one cycle after the address wrapped to 0
module frame_addr_counter #(
  parameter int ADDR_WIDTH  = 24,
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wrap_pulse
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BURST_LEN);

  // Comparing against the last burst start (rather than addr+STEP against
  // FRAME_WORDS) keeps the arithmetic inside ADDR_WIDTH bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (advance) begin
        if (addr == LAST_ADDR) begin
          addr       <= '0;
          wrap_pulse <= 1'b1;
        end else begin
          addr <= addr + STEP;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter
// Memory-side scheduler between the camera FIFO (drained to memory) and the
// display FIFO (refilled from memory). Issues fixed-length burst commands on
// a single memory command port, arbitrating by FIFO fill level with an urgent
// display-refill override and round-robin otherwise. Pixel data bypasses this
// block; it only generates the FIFO pop/push strobes.
// Ports:
//   clk, rst_n        : memory clock, asynchronous active-low reset
//   enable            : scheduling enable (memory initialised)
//   wr_fifo_count     : camera FIFO fill level (lagging, pessimistic)
//   wr_fifo_read      : camera FIFO pop, one per write beat
//   rd_fifo_count     : display FIFO fill level (lagging, pessimistic)
//   rd_fifo_full      : display FIFO full flag
//   rd_fifo_write     : display FIFO push, one per read beat
//   mem_cmd_valid/ready/rw/addr : burst command handshake (rw 1 = write)
//   mem_wdata_ready   : memory takes a write word this cycle
//   mem_rdata_valid   : memory delivers a read word this cycle
//   frame_wr_done/frame_rd_done : one-cycle pulse on frame address wrap
module fifo_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int BURST_LEN        = 256,
  parameter int ADDR_WIDTH       = 24,
  parameter int FRAME_WORDS      = 307200,
  parameter int URGENT_LVL       = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [FIFO_DEPTH_WIDTH-1:0] wr_fifo_count,
  output logic                        wr_fifo_read,
  input  logic [FIFO_DEPTH_WIDTH-1:0] rd_fifo_count,
  input  logic                        rd_fifo_full,
  output logic                        rd_fifo_write,
  output logic                        mem_cmd_valid,
  input  logic                        mem_cmd_ready,
  output logic                        mem_cmd_rw,
  output logic [ADDR_WIDTH-1:0]       mem_cmd_addr,
  input  logic                        mem_wdata_ready,
  input  logic                        mem_rdata_valid,
  output logic                        frame_wr_done,
  output logic                        frame_rd_done
);

  localparam int BEAT_W = clog2(BURST_LEN) + 1;
  localparam int CNT_W  = FIFO_DEPTH_WIDTH + 1;

  localparam logic [CNT_W-1:0]  BURST_CNT  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  RD_MAX_CNT = CNT_W'((1 << FIFO_DEPTH_WIDTH) - BURST_LEN);
  localparam logic [CNT_W-1:0]  URGENT_CNT = CNT_W'(URGENT_LVL);
  localparam logic [BEAT_W-1:0] BEATS_FULL = BEAT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);

  // Reject configurations that break the burst/frame/FIFO size relationships.
  if (DATA_WIDTH < 1 || BURST_LEN < 1 || (BURST_LEN & (BURST_LEN - 1)) != 0 ||
      2 * BURST_LEN > (1 << FIFO_DEPTH_WIDTH) || (FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_cfg
    $error("fifo_burst_arbiter: invalid parameter combination");
  end

  arb_state_t             state, state_nxt;
  grant_t                 last_grant;
  logic [BEAT_W-1:0]      beats;
  logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;
  logic                   wr_elig, rd_elig, rd_urgent;
  logic                   cmd_accept, wr_pop, rd_push, wr_adv, rd_adv;

  // Zero-extend counts so the thresholds compare at a common width.
  assign wr_elig   = {1'b0, wr_fifo_count} >= BURST_CNT;
  assign rd_elig   = !rd_fifo_full && ({1'b0, rd_fifo_count} <= RD_MAX_CNT);
  assign rd_urgent = {1'b0, rd_fifo_count} < URGENT_CNT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_accept = 1'b0;
    wr_pop     = 1'b0;
    rd_push    = 1'b0;
    wr_adv     = 1'b0;
    rd_adv     = 1'b0;
    case (state)
      IDLE: if (enable) state_nxt = ARB;
      ARB: begin
        if (!enable)                    state_nxt = IDLE;
        else if (rd_elig && rd_urgent)  state_nxt = RD_CMD;
        else if (wr_elig && rd_elig)    state_nxt = (last_grant == GRANT_RD) ? WR_CMD : RD_CMD;
        else if (wr_elig)               state_nxt = WR_CMD;
        else if (rd_elig)               state_nxt = RD_CMD;
      end
      WR_CMD: if (mem_cmd_ready) begin
        cmd_accept = 1'b1;
        state_nxt  = WR_DATA;
      end
      RD_CMD: if (mem_cmd_ready) begin
        cmd_accept = 1'b1;
        state_nxt  = RD_DATA;
      end
      // The burst ends on the cycle of its final beat, so the next burst can
      // be arbitrated immediately afterwards.
      WR_DATA: begin
        wr_pop = mem_wdata_ready && (beats != '0);
        if (beats == '0 || (wr_pop && beats == BEAT_ONE)) begin
          wr_adv    = 1'b1;
          state_nxt = ARB;
        end
      end
      RD_DATA: begin
        rd_push = mem_rdata_valid && (beats != '0);
        if (beats == '0 || (rd_push && beats == BEAT_ONE)) begin
          rd_adv    = 1'b1;
          state_nxt = ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fifo_read  = wr_pop;
  assign rd_fifo_write = rd_push;

  // Command fields are captured once at the grant and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cmd_valid <= 1'b0;
      mem_cmd_rw    <= 1'b0;
      mem_cmd_addr  <= '0;
      beats         <= '0;
      last_grant    <= GRANT_RD;
    end else begin
      if (state == ARB && (state_nxt == WR_CMD || state_nxt == RD_CMD)) begin
        mem_cmd_valid <= 1'b1;
        mem_cmd_rw    <= (state_nxt == WR_CMD);
        mem_cmd_addr  <= (state_nxt == WR_CMD) ? wr_addr : rd_addr;
      end else if (cmd_accept) begin
        mem_cmd_valid <= 1'b0;
      end

      if (cmd_accept) begin
        beats      <= BEATS_FULL;
        last_grant <= (state == WR_CMD) ? GRANT_WR : GRANT_RD;
      end else if (wr_pop || rd_push) begin
        beats <= beats - BEAT_ONE;
      end
    end
  end

  frame_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_wr_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (wr_adv),
    .addr      (wr_addr),
    .wrap_pulse(frame_wr_done)
  );

  frame_addr_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_rd_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (rd_adv),
    .addr      (rd_addr),
    .wrap_pulse(frame_rd_done)
  );

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
`timescale 1ns/1ps
module tb_fifo_burst_arbiter;

  localparam int DW    = 16;
  localparam int FDW   = 10;
  localparam int BL    = 256;
  localparam int AW    = 24;
  localparam int FW    = 1024;
  localparam int URG   = 256;
  localparam int DEPTH = 1 << FDW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [FDW-1:0] wr_fifo_count = '0;
  logic [FDW-1:0] rd_fifo_count = '0;
  logic           rd_fifo_full = 1'b0;
  logic           mem_cmd_ready = 1'b0;
  logic           mem_wdata_ready = 1'b0;
  logic           mem_rdata_valid = 1'b0;
  logic           wr_fifo_read, rd_fifo_write, mem_cmd_valid, mem_cmd_rw;
  logic [AW-1:0]  mem_cmd_addr;
  logic           frame_wr_done, frame_rd_done;

  fifo_burst_arbiter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(FDW), .BURST_LEN(BL),
    .ADDR_WIDTH(AW), .FRAME_WORDS(FW), .URGENT_LVL(URG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wr_fifo_count(wr_fifo_count), .wr_fifo_read(wr_fifo_read),
    .rd_fifo_count(rd_fifo_count), .rd_fifo_full(rd_fifo_full),
    .rd_fifo_write(rd_fifo_write),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_rw(mem_cmd_rw), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata_ready(mem_wdata_ready), .mem_rdata_valid(mem_rdata_valid),
    .frame_wr_done(frame_wr_done), .frame_rd_done(frame_rd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Handshake input drivers: 0 = low, 1 = high, 2 = random.
  int cready_mode = 1;
  int wdr_mode    = 1;
  int rdv_mode    = 1;

  always @(posedge clk) begin
    #1;
    mem_cmd_ready   = (cready_mode == 2) ? ($urandom_range(0, 1) == 1) : (cready_mode == 1);
    mem_wdata_ready = (wdr_mode == 2) ? ($urandom_range(0, 3) != 0) : (wdr_mode == 1);
    mem_rdata_valid = (rdv_mode == 2) ? ($urandom_range(0, 2) != 0) : (rdv_mode == 1);
  end

  // ---------------- behavioural model ----------------
  // Activity the scheduler is engaged in as seen from outside: waiting to be
  // enabled, choosing, offering a command, or moving burst words.
  typedef enum int {M_OFF, M_CHOOSE, M_OFFER, M_WRITE, M_READ} act_t;
  act_t m_act = M_OFF;
  bit   m_dir;            // 1 = write
  int   m_cmd_addr;
  int   m_left;
  int   m_waddr = 0, m_raddr = 0;
  bit   m_last_wr = 1'b0;
  bit   m_wwrap = 1'b0, m_rwrap = 1'b0;

  typedef struct { bit rw; int addr; } cmd_t;
  cmd_t cmd_log[$];
  int   wr_pulses = 0, rd_pulses = 0, wdone_pulses = 0, rdone_pulses = 0;

  // Which direction the rules grant with the inputs as they are now: 1 write,
  // 0 read, -1 nothing eligible.
  function automatic int pick();
    bit we, re;
    we = int'(wr_fifo_count) >= BL;
    re = !rd_fifo_full && int'(rd_fifo_count) <= DEPTH - BL;
    if (re && int'(rd_fifo_count) < URG) return 0;
    if (we && re) return m_last_wr ? 0 : 1;
    if (we) return 1;
    if (re) return 0;
    return -1;
  endfunction

  always @(negedge clk) begin
    bit e_wr, e_rd;
    int d;
    if (!rst_n) begin
      m_act = M_OFF; m_waddr = 0; m_raddr = 0; m_last_wr = 1'b0;
      m_wwrap = 1'b0; m_rwrap = 1'b0;
      chk("outputs_in_reset",
          longint'({wr_fifo_read, rd_fifo_write, mem_cmd_valid, mem_cmd_rw,
                    mem_cmd_addr, frame_wr_done, frame_rd_done}), 0);
    end else begin
      e_wr = (m_act == M_WRITE) && m_left > 0 && mem_wdata_ready;
      e_rd = (m_act == M_READ)  && m_left > 0 && mem_rdata_valid;
      chk("cmd_valid", longint'(mem_cmd_valid), longint'(m_act == M_OFFER));
      if (m_act == M_OFFER) begin
        chk("cmd_rw", longint'(mem_cmd_rw), longint'(m_dir));
        chk("cmd_addr", longint'(mem_cmd_addr), longint'(m_cmd_addr));
      end
      chk("wr_fifo_read", longint'(wr_fifo_read), longint'(e_wr));
      chk("rd_fifo_write", longint'(rd_fifo_write), longint'(e_rd));
      chk("frame_wr_done", longint'(frame_wr_done), longint'(m_wwrap));
      chk("frame_rd_done", longint'(frame_rd_done), longint'(m_rwrap));

      if (mem_cmd_valid && mem_cmd_ready) cmd_log.push_back('{mem_cmd_rw, int'(mem_cmd_addr)});
      if (wr_fifo_read)  wr_pulses++;
      if (rd_fifo_write) rd_pulses++;
      if (frame_wr_done) wdone_pulses++;
      if (frame_rd_done) rdone_pulses++;

      m_wwrap = 1'b0;
      m_rwrap = 1'b0;
      case (m_act)
        M_OFF: if (enable) m_act = M_CHOOSE;
        M_CHOOSE: begin
          if (!enable) m_act = M_OFF;
          else begin
            d = pick();
            if (d >= 0) begin
              m_act = M_OFFER;
              m_dir = (d == 1);
              m_cmd_addr = m_dir ? m_waddr : m_raddr;
            end
          end
        end
        M_OFFER: if (mem_cmd_ready) begin
          m_last_wr = m_dir;
          m_left = BL;
          m_act = m_dir ? M_WRITE : M_READ;
        end
        M_WRITE: begin
          if (e_wr) m_left--;
          if (m_left == 0) begin
            m_waddr += BL;
            if (m_waddr == FW) begin m_waddr = 0; m_wwrap = 1'b1; end
            m_act = M_CHOOSE;
          end
        end
        M_READ: begin
          if (e_rd) m_left--;
          if (m_left == 0) begin
            m_raddr += BL;
            if (m_raddr == FW) begin m_raddr = 0; m_rwrap = 1'b1; end
            m_act = M_CHOOSE;
          end
        end
        default: m_act = M_OFF;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  int log_base = 0, base_wr = 0, base_rd = 0, base_wdone = 0, base_rdone = 0;

  function automatic int ncmd();
    return cmd_log.size() - log_base;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic do_reset();
    enable = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("async_reset_immediate",
           longint'({wr_fifo_read, rd_fifo_write, mem_cmd_valid, mem_cmd_rw,
                     mem_cmd_addr, frame_wr_done, frame_rd_done}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    log_base = cmd_log.size();
    base_wr = wr_pulses; base_rd = rd_pulses;
    base_wdone = wdone_pulses; base_rdone = rdone_pulses;
    cyc(1);
  endtask

  task automatic wait_cmds(input string name, input int n, input int budget);
    int k = 0;
    while (ncmd() < n && k < budget) begin cyc(1); k++; end
    chk(name, longint'(ncmd() >= n), 1);
  endtask

  task automatic chk_cmd(input string name, input int idx, input bit rw, input int addr);
    if (ncmd() > idx) begin
      chk({name, "_rw"}, longint'(cmd_log[log_base + idx].rw), longint'(rw));
      chk({name, "_addr"}, longint'(cmd_log[log_base + idx].addr), longint'(addr));
    end else begin
      chk({name, "_missing"}, longint'(ncmd()), longint'(idx + 1));
    end
  endtask

  initial begin
    bit [AW-1:0] hold_addr;
    bit          hold_rw;
    int          k;

    cyc(3);
    chk("reset_cmd_valid", longint'(mem_cmd_valid), 0);
    chk("reset_cmd_addr", longint'(mem_cmd_addr), 0);
    chk("reset_strobes", longint'({wr_fifo_read, rd_fifo_write}), 0);
    do_reset();

    // Single write burst, then the next one at the following address.
    wr_fifo_count = 10'd300; rd_fifo_full = 1'b1; rd_fifo_count = '0;
    cready_mode = 1; wdr_mode = 1; rdv_mode = 1;
    enable = 1'b1;
    wait_cmds("A_two_cmds", 2, 1000);
    chk_cmd("A_cmd0", 0, 1'b1, 0);
    chk_cmd("A_cmd1", 1, 1'b1, 256);
    chk("A_pops_one_burst", longint'(wr_pulses - base_wr), 256);
    do_reset();

    // Urgent display refill beats a loaded camera FIFO; gappy read data.
    wr_fifo_count = 10'd600; rd_fifo_count = 10'd100; rd_fifo_full = 1'b0;
    rdv_mode = 2;
    enable = 1'b1;
    wait_cmds("B_two_cmds", 2, 2000);
    chk_cmd("B_cmd0", 0, 1'b0, 0);
    chk_cmd("B_cmd1", 1, 1'b0, 256);
    chk("B_push_one_burst", longint'(rd_pulses - base_rd), 256);
    do_reset();

    // Round-robin once both are eligible, after a write-only first burst.
    rdv_mode = 1;
    wr_fifo_count = 10'd600; rd_fifo_count = 10'd400; rd_fifo_full = 1'b1;
    enable = 1'b1;
    wait_cmds("C_first", 1, 100);
    rd_fifo_full = 1'b0;
    wait_cmds("C_five", 5, 3000);
    chk_cmd("C_cmd0", 0, 1'b1, 0);
    chk_cmd("C_cmd1", 1, 1'b0, 0);
    chk_cmd("C_cmd2", 2, 1'b1, 256);
    chk_cmd("C_cmd3", 3, 1'b0, 256);
    chk_cmd("C_cmd4", 4, 1'b1, 512);
    do_reset();

    // Frame wrap after four write bursts of a 1024-word frame.
    wr_fifo_count = 10'd600; rd_fifo_full = 1'b1;
    enable = 1'b1;
    wait_cmds("D_five", 5, 3000);
    chk_cmd("D_cmd3", 3, 1'b1, 768);
    chk_cmd("D_cmd4", 4, 1'b1, 0);
    chk("D_wr_wraps", longint'(wdone_pulses - base_wdone), 1);
    chk("D_rd_wraps", longint'(rdone_pulses - base_rdone), 0);
    do_reset();

    // Command backpressure, then enable dropped mid-burst.
    wr_fifo_count = 10'd600; rd_fifo_full = 1'b1;
    cready_mode = 0; wdr_mode = 2;
    enable = 1'b1;
    k = 0;
    while (!mem_cmd_valid && k < 20) begin cyc(1); k++; end
    chk("E_cmd_raised", longint'(mem_cmd_valid), 1);
    hold_addr = mem_cmd_addr; hold_rw = mem_cmd_rw;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("E_stall_stable",
          longint'({mem_cmd_valid, mem_cmd_rw, mem_cmd_addr}),
          longint'({1'b1, hold_rw, hold_addr}));
    end
    cready_mode = 1;
    wait_cmds("E_accept", 1, 20);
    k = 0;
    while (wr_pulses - base_wr < 50 && k < 200) begin cyc(1); k++; end
    enable = 1'b0;
    k = 0;
    while (wr_pulses - base_wr < 256 && k < 1000) begin cyc(1); k++; end
    cyc(20);
    chk("E_full_burst", longint'(wr_pulses - base_wr), 256);
    chk("E_no_new_cmd", longint'(ncmd()), 1);
    chk("E_idle_valid", longint'(mem_cmd_valid), 0);
    wdr_mode = 1;
    do_reset();

    // Reset in the middle of a read burst.
    wr_fifo_count = '0; rd_fifo_count = 10'd100; rd_fifo_full = 1'b0;
    enable = 1'b1;
    wait_cmds("F_first", 1, 100);
    k = 0;
    while (rd_pulses - base_rd < 100 && k < 600) begin cyc(1); k++; end
    chk("F_reached_beat100", longint'(rd_pulses - base_rd), 100);
    do_reset();
    enable = 1'b1;
    wait_cmds("F_after_reset", 1, 100);
    chk_cmd("F_cmd0", 0, 1'b0, 0);
    do_reset();

    // Randomized traffic against the model.
    cready_mode = 2; wdr_mode = 2; rdv_mode = 2;
    enable = 1'b1;
    for (int i = 0; i < 7000; i++) begin
      if ($urandom_range(0, 7) == 0) wr_fifo_count = FDW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) rd_fifo_count = FDW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) rd_fifo_full = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      cyc(1);
    end
    chk("G_progress", longint'(ncmd() > 5), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
